// File: rtl/quad_decoder.sv
//------------------------------------------------------------------------------
// quad_decoder : A/B quadrature decoder -> step/dir pulses + position, err flag
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module quad_decoder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] position,
  output logic             err
);

  localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic [1:0]             filt_ab_q;
  logic [CNT_W-1:0]       filt_cnt_q;
  logic [CNT_W-1:0]       stable_cnt_q;
  logic [1:0]             prev_ab_q;

  logic [1:0] sync_ab;
  logic       sync_match;
  logic       accept;
  logic [1:0] up_of_prev;
  logic [1:0] up_of_filt;
  logic       is_up;
  logic       is_down;
  logic       is_illegal;
  logic       moved;

  // Successor of an AB code along the up sequence 00->01->11->10->00.
  function automatic logic [1:0] up_next(input logic [1:0] ab);
    case (ab)
      2'b00:   up_next = 2'b01;
      2'b01:   up_next = 2'b11;
      2'b11:   up_next = 2'b10;
      default: up_next = 2'b00;
    endcase
  endfunction

  always_comb begin
    sync_ab    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    sync_match = (sync_ab == filt_ab_q);
    accept     = !sync_match && (filt_cnt_q == FILT_LAST);
    up_of_prev = up_next(prev_ab_q);
    up_of_filt = up_next(filt_ab_q);
    moved      = (filt_ab_q != prev_ab_q);
    is_up      = moved && (filt_ab_q == up_of_prev);
    is_down    = moved && (prev_ab_q == up_of_filt);
    is_illegal = moved && ((filt_ab_q ^ prev_ab_q) == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      a_sync_q     <= '0;
      b_sync_q     <= '0;
      filt_ab_q    <= 2'b00;
      filt_cnt_q   <= '0;
      stable_cnt_q <= '0;
      prev_ab_q    <= 2'b00;
      step         <= 1'b0;
      dir          <= 1'b0;
      position     <= '0;
      err          <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};

      if (sync_match) begin
        filt_cnt_q <= '0;
      end else if (accept) begin
        filt_ab_q  <= sync_ab;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + CNT_W'(1);
      end

      step <= 1'b0;
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state_q)
        INIT: begin
          // Lock onto whatever level the encoder rests at; no step is issued.
          if (accept) begin
            prev_ab_q <= sync_ab;
            state_q   <= TRACK;
          end else if (sync_match) begin
            if (stable_cnt_q == FILT_LAST) begin
              prev_ab_q <= filt_ab_q;
              state_q   <= TRACK;
            end else begin
              stable_cnt_q <= stable_cnt_q + CNT_W'(1);
            end
          end else begin
            stable_cnt_q <= '0;
          end
        end
        TRACK: begin
          if (moved) begin
            prev_ab_q <= filt_ab_q;
          end
          if (is_up) begin
            step     <= 1'b1;
            dir      <= 1'b1;
            position <= position + WIDTH'(1);
          end else if (is_down) begin
            step     <= 1'b1;
            dir      <= 1'b0;
            position <= position - WIDTH'(1);
          end else if (is_illegal) begin
            err <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase

      if (clear) begin
        position <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
//------------------------------------------------------------------------------
// tb_quad_decoder : directed vector bench for quad_decoder
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_quad_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_in;
  logic        b_in;
  logic        clear;
  logic        err_clr;
  logic        step;
  logic        dir;
  logic [15:0] position;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  quad_decoder #(.WIDTH(16), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_in     (a_in),
    .b_in     (b_in),
    .clear    (clear),
    .err_clr  (err_clr),
    .step     (step),
    .dir      (dir),
    .position (position),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ab;
    int          steps;
    logic        dir;
    logic [15:0] pos;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Hold a pin level for 10 cycles; expect exp_steps pulses, each 6 edges in.
  task automatic drive_level(input string nm, input logic [1:0] ab, input int exp_steps,
                             input logic exp_dir, input logic [15:0] exp_pos,
                             input logic exp_err);
    int steps = 0;
    int at    = 0;
    {a_in, b_in} = ab;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step === 1'b1) begin
        steps++;
        at = i;
      end
    end
    chk({nm, " steps"}, 32'(steps), 32'(exp_steps));
    if (exp_steps == 1) chk({nm, " latency"}, 32'(at), 32'd6);
    chk({nm, " dir"}, {31'd0, dir}, {31'd0, exp_dir});
    chk({nm, " position"}, {16'd0, position}, {16'd0, exp_pos});
    chk({nm, " err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    int steps;
    vecs[0] = '{2'b01, 1, 1'b1, 16'h0001, 1'b0};
    vecs[1] = '{2'b11, 1, 1'b1, 16'h0002, 1'b0};
    vecs[2] = '{2'b10, 1, 1'b1, 16'h0003, 1'b0};
    vecs[3] = '{2'b00, 1, 1'b1, 16'h0004, 1'b0};
    vecs[4] = '{2'b10, 1, 1'b0, 16'h0003, 1'b0};
    vecs[5] = '{2'b11, 1, 1'b0, 16'h0002, 1'b0};
    vecs[6] = '{2'b01, 1, 1'b0, 16'h0001, 1'b0};
    vecs[7] = '{2'b00, 1, 1'b0, 16'h0000, 1'b0};
    vecs[8] = '{2'b10, 1, 1'b0, 16'hFFFF, 1'b0};
    vecs[9] = '{2'b00, 1, 1'b1, 16'h0000, 1'b0};

    reset = 1'b1; a_in = 1'b1; b_in = 1'b1; clear = 1'b0; err_clr = 1'b0;
    tick();
    chk("reset step", {31'd0, step}, 32'd0);
    chk("reset dir", {31'd0, dir}, 32'd0);
    chk("reset position", {16'd0, position}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    tick();
    reset = 1'b0;
    drive_level("init at 11", 2'b11, 0, 1'b0, 16'h0000, 1'b0);

    reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    drive_level("init at 00", 2'b00, 0, 1'b0, 16'h0000, 1'b0);

    foreach (vecs[i]) begin
      drive_level($sformatf("vec%0d", i), vecs[i].ab, vecs[i].steps, vecs[i].dir,
                  vecs[i].pos, vecs[i].err);
    end

    // Two-cycle glitch on A must be filtered out.
    a_in = 1'b1;
    tick(); tick();
    a_in = 1'b0;
    drive_level("glitch", 2'b00, 0, 1'b1, 16'h0000, 1'b0);

    drive_level("jump 00->11", 2'b11, 0, 1'b1, 16'h0000, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", {31'd0, err}, 32'd0);

    // Illegal jump detected on the same edge err_clr is high: set wins.
    {a_in, b_in} = 2'b00;
    err_clr = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    chk("err before detect", {31'd0, err}, 32'd0);
    tick();
    err_clr = 1'b0;
    chk("err set wins", {31'd0, err}, 32'd1);
    drive_level("after set wins", 2'b00, 0, 1'b1, 16'h0000, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    drive_level("fwd1", 2'b01, 1, 1'b1, 16'h0001, 1'b0);
    drive_level("fwd2", 2'b11, 1, 1'b1, 16'h0002, 1'b0);
    drive_level("fwd3", 2'b10, 1, 1'b1, 16'h0003, 1'b0);
    drive_level("fwd4", 2'b00, 1, 1'b1, 16'h0004, 1'b0);
    drive_level("fwd5", 2'b01, 1, 1'b1, 16'h0005, 1'b0);
    drive_level("fwd6", 2'b11, 1, 1'b1, 16'h0006, 1'b0);
    drive_level("fwd7", 2'b10, 1, 1'b1, 16'h0007, 1'b0);

    // clear coincident with a forward step from position 7.
    {a_in, b_in} = 2'b00;
    steps = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (step === 1'b1) steps++;
    end
    chk("clear early steps", 32'(steps), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear step", {31'd0, step}, 32'd1);
    chk("clear dir", {31'd0, dir}, 32'd1);
    chk("clear position", {16'd0, position}, 32'd0);
    drive_level("after clear", 2'b00, 0, 1'b1, 16'h0000, 1'b0);

    drive_level("pre-reset fwd", 2'b01, 1, 1'b1, 16'h0001, 1'b0);
    // Reset three cycles into a pending transition discards it.
    {a_in, b_in} = 2'b11;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset step", {31'd0, step}, 32'd0);
    chk("midreset dir", {31'd0, dir}, 32'd0);
    chk("midreset position", {16'd0, position}, 32'd0);
    steps = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (step === 1'b1) steps++;
    end
    chk("midreset no step", 32'(steps), 32'd0);
    chk("midreset position after", {16'd0, position}, 32'd0);
    chk("midreset err after", {31'd0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
